// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: control from decode, instruction-memory port and IF/ID outputs.
interface fetch_if;

    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [29:0] imem_addr_o;
    logic [31:0] imem_q_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_valid_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_q_i,
        output imem_addr_o, if_pc_o, if_instr_o, if_valid_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_q_i,
        input  imem_addr_o, if_pc_o, if_instr_o, if_valid_o
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry skid register that keeps a stalled instruction after the memory moves on.
module fetch_hold_buf (
    input  logic        clock,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] live_i,
    output logic [31:0] instr_o
);

    logic [31:0] hold_instr_q;
    logic        hold_valid_q;

    // Clear wins over load so a redirect always discards the held word.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            hold_instr_q <= '0;
            hold_valid_q <= 1'b0;
        end else if (clear_i) begin
            hold_valid_q <= 1'b0;
        end else if (load_i) begin
            hold_instr_q <= live_i;
            hold_valid_q <= 1'b1;
        end
    end

    assign instr_o = hold_valid_q ? hold_instr_q : live_i;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, memory address, and PC/instruction pairing for IF/ID.
// Optional FETCH_MISALIGN_CHECK_EN adds a registered misaligned-redirect pulse.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clock,
    input  logic     rst,
    fetch_if.master  fif
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic     fetch_misalign_o
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  rsp_pc_q, rsp_pc_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         hold_load, hold_clr;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            pc_q        <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_valid_d = rsp_valid_q;
        hold_load   = 1'b0;
        hold_clr    = 1'b0;
        if (fif.redirect_i) begin
            pc_d        = {fif.redirect_pc_i[31:2], 2'b00};
            rsp_valid_d = 1'b0;
            hold_clr    = 1'b1;
            state_d     = FILL;
        end else begin
            unique case (state_q)
                FILL: begin
                    rsp_pc_d    = pc_q;
                    rsp_valid_d = 1'b1;
                    pc_d        = pc_q + PC_STEP;
                    state_d     = RUN;
                end
                RUN: begin
                    if (fif.stall_i) begin
                        hold_load = 1'b1;
                        state_d   = STALL;
                    end else begin
                        rsp_pc_d = pc_q;
                        pc_d     = pc_q + PC_STEP;
                    end
                end
                STALL: begin
                    // Held word is consumed this edge; memory already has pc_q in flight.
                    if (!fif.stall_i) begin
                        hold_clr = 1'b1;
                        rsp_pc_d = pc_q;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = RUN;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    fetch_hold_buf u_hold_buf (
        .clock   (clock),
        .rst     (rst),
        .load_i  (hold_load),
        .clear_i (hold_clr),
        .live_i  (fif.imem_q_i),
        .instr_o (fif.if_instr_o)
    );

    assign fif.imem_addr_o = pc_q[31:2];
    assign fif.if_pc_o     = rsp_pc_q;
    assign fif.if_valid_o  = rsp_valid_q & ~fif.redirect_i;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= fif.redirect_i & (|fif.redirect_pc_i[1:0]);
        end
    end

    assign fetch_misalign_o = misalign_q;
`else
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^fif.redirect_pc_i[1:0];
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed literal checks plus randomized stall/redirect
// traffic checked every cycle against a stream-level model of the fetch output.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic clock;
    logic rst;
    int   n_checks;
    int   n_errors;

    fetch_if fif ();

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fetch_misalign_o;
`endif

    fetch_unit #(
        .RESET_PC (RST_PC)
    ) dut (
        .clock            (clock),
        .rst              (rst),
        .fif              (fif)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign_o (fetch_misalign_o)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_at(input logic [31:0] pc);
        return 32'hA000_0000 + (pc >> 2);
    endfunction

    // Synchronous-read instruction memory: mem[i] = A0000000 + i.
    always @(posedge clock) fif.imem_q_i <= 32'hA000_0000 + {2'b00, fif.imem_addr_o};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: next PC to deliver, plus count of bubble cycles still owed.
    logic [31:0] m_pc;
    int          m_bub;
    logic        m_mis;

    always @(negedge clock) begin
        if (!rst) begin
            m_pc  = RST_PC;
            m_bub = 1;
            m_mis = 1'b0;
            chk1("rst_valid", fif.if_valid_o, 1'b0);
            chk("rst_pc", fif.if_pc_o, RST_PC);
            chk("rst_addr", {2'b00, fif.imem_addr_o}, {2'b00, RST_PC[31:2]});
            chk("rst_instr_passthru", fif.if_instr_o, fif.imem_q_i);
`ifdef FETCH_MISALIGN_CHECK_EN
            chk1("rst_misalign", fetch_misalign_o, 1'b0);
`endif
        end else begin
            chk1("valid", fif.if_valid_o, (m_bub == 0) && !fif.redirect_i);
            if ((m_bub == 0) && !fif.redirect_i) begin
                chk("pc", fif.if_pc_o, m_pc);
                chk("instr", fif.if_instr_o, mem_at(m_pc));
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            chk1("misalign", fetch_misalign_o, m_mis);
`endif
            m_mis = fif.redirect_i && (fif.redirect_pc_i[1:0] != 2'b00);
            if (fif.redirect_i) begin
                m_pc  = {fif.redirect_pc_i[31:2], 2'b00};
                m_bub = 1;
            end else if (m_bub != 0) begin
                m_bub--;
            end else if (!fif.stall_i) begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic step(input logic stall, input logic redir, input logic [31:0] tgt);
        @(posedge clock);
        #1;
        fif.stall_i       = stall;
        fif.redirect_i    = redir;
        fif.redirect_pc_i = tgt;
        @(negedge clock);
    endtask

    task automatic lit_ins(input string name, input logic [31:0] pc, input logic [31:0] instr);
        chk1({name, "_valid"}, fif.if_valid_o, 1'b1);
        chk({name, "_pc"}, fif.if_pc_o, pc);
        chk({name, "_instr"}, fif.if_instr_o, instr);
    endtask

    task automatic lit_bubble(input string name);
        chk1({name, "_valid"}, fif.if_valid_o, 1'b0);
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        rst               = 1'b0;
        fif.stall_i       = 1'b0;
        fif.redirect_i    = 1'b0;
        fif.redirect_pc_i = '0;
        repeat (3) @(negedge clock);

        // Release reset; PCs wrap through zero from the top of the space.
        @(posedge clock);
        #1 rst = 1'b1;
        @(negedge clock);
        lit_bubble("c1");
        step(1'b0, 1'b0, 32'h0); lit_ins("c2", 32'hFFFF_FFF8, 32'hDFFF_FFFE);
        step(1'b0, 1'b0, 32'h0); lit_ins("c3", 32'hFFFF_FFFC, 32'hDFFF_FFFF);

        // Three-cycle stall: one PC shown four cycles, nothing skipped.
        step(1'b1, 1'b0, 32'h0); lit_ins("st0", 32'h0000_0000, 32'hA000_0000);
        step(1'b1, 1'b0, 32'h0); lit_ins("st1", 32'h0000_0000, 32'hA000_0000);
        step(1'b1, 1'b0, 32'h0); lit_ins("st2", 32'h0000_0000, 32'hA000_0000);
        step(1'b0, 1'b0, 32'h0); lit_ins("st3", 32'h0000_0000, 32'hA000_0000);
        step(1'b0, 1'b0, 32'h0); lit_ins("st4", 32'h0000_0004, 32'hA000_0001);
        step(1'b0, 1'b0, 32'h0); lit_ins("st5", 32'h0000_0008, 32'hA000_0002);

        // Redirect: two bubbles, then the target.
        step(1'b0, 1'b1, 32'h40); lit_bubble("rd0");
        step(1'b0, 1'b0, 32'h0);  lit_bubble("rd1");
        step(1'b0, 1'b0, 32'h0);  lit_ins("rd2", 32'h0000_0040, 32'hA000_0010);

        // Redirect together with stall mid-stall discards the held word.
        step(1'b1, 1'b0, 32'h0);  lit_ins("rs0", 32'h0000_0044, 32'hA000_0011);
        step(1'b1, 1'b0, 32'h0);  lit_ins("rs1", 32'h0000_0044, 32'hA000_0011);
        step(1'b1, 1'b1, 32'h80); lit_bubble("rs2");
        step(1'b1, 1'b0, 32'h0);  lit_bubble("rs3");
        step(1'b0, 1'b0, 32'h0);  lit_ins("rs4", 32'h0000_0080, 32'hA000_0020);
        step(1'b0, 1'b0, 32'h0);  lit_ins("rs5", 32'h0000_0084, 32'hA000_0021);

        // Asynchronous reset mid-stall, then a misaligned redirect.
        step(1'b1, 1'b0, 32'h0);  lit_ins("ar0", 32'h0000_0088, 32'hA000_0022);
        @(posedge clock);
        #3 rst = 1'b0;
        #1;
        chk1("ar_valid", fif.if_valid_o, 1'b0);
        chk("ar_pc", fif.if_pc_o, RST_PC);
        @(posedge clock);
        #1;
        rst         = 1'b1;
        fif.stall_i = 1'b0;
        @(negedge clock);
        lit_bubble("ar1");
        step(1'b0, 1'b1, 32'h42); lit_bubble("mr0");
        step(1'b0, 1'b0, 32'h0);  lit_bubble("mr1");
`ifdef FETCH_MISALIGN_CHECK_EN
        chk1("mr1_pulse", fetch_misalign_o, 1'b1);
`endif
        step(1'b0, 1'b0, 32'h0);  lit_ins("mr2", 32'h0000_0040, 32'hA000_0010);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk1("mr2_pulse", fetch_misalign_o, 1'b0);
`endif

        // Randomized traffic, checked by the model process every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock);
            #1;
            rst            = ($urandom_range(0, 299) != 0);
            fif.stall_i    = ($urandom_range(0, 9) < 3);
            fif.redirect_i = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0) fif.redirect_pc_i = $urandom_range(0, 1023);
            else fif.redirect_pc_i = $urandom;
        end
        @(posedge clock);
        #1;
        rst            = 1'b1;
        fif.stall_i    = 1'b0;
        fif.redirect_i = 1'b0;
        repeat (4) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
